fu_alu_pipe: RTL and testbench
==============================

// Module: fu_alu_pipe
// PURPOSE
//  Pipelined multi-op integer functional unit; next generation of the single-op FU_* units.
//  Takes one op per cycle from dispatch, keeps up to LATENCY ops in flight and returns each
//  result with its execution tag. Results leave only when the broadcast queue accepts them.
//  Sits between the reservation-station dispatch and the broadcast queue.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width (>=8, power of 2)
//  LATENCY     1   issue-to-done cycles (>=1); also the number of pipeline stages
//  TAG_WIDTH   7   execution tag width
//  OP_WIDTH    4   opcode width (fixed encoding from fu_pkg)
// PORTS
//  clk               in   1           clock, all state on posedge
//  rst               in   1           synchronous, active-high reset
//  ce                in   1           issue strobe; valid only while idle=1
//  idle              out  1           stage 1 can accept an op this cycle
//  op                in   OP_WIDTH    operation select
//  executionTag_in   in   TAG_WIDTH   tag of the issued op
//  data_0            in   DATA_WIDTH  operand 0 (subtrahend / shift amount / rhs)
//  data_1            in   DATA_WIDTH  operand 1 (minuend / shifted value / lhs)
//  result            out  DATA_WIDTH  result of the op at the output stage
//  done              out  1           output stage holds a valid result
//  executionTag_out  out  TAG_WIDTH   tag matching result
//  queued            in   1           broadcast queue accepted result this cycle
//  zero_flag         out  1           [FU_ALU_FLAGS_EN only] result == 0
//  ovf_flag          out  1           [FU_ALU_FLAGS_EN only] signed overflow on ADD/SUB
// BEHAVIOUR
//  - Reset: all stage valids=0, done=0, result=0, executionTag_out=0, idle=1 after the reset edge;
//    in-flight ops are dropped. ce is ignored while rst=1.
//  - Ops: ADD d1+d0; SUB d1-d0; AND/OR/XOR; SLL/SRL/SRA d1 by d0[$clog2(DATA_WIDTH)-1:0];
//    SLT signed d1<d0; SLTU unsigned d1<d0, giving zero-extended 1/0. Undefined opcodes give 0.
//    Arithmetic wraps modulo 2^DATA_WIDTH.
//  - Stage 1 registers op, tag and operands on ce&idle. Result is computed from stage 1 regs and
//    carried through stages 2..LATENCY. done = valid of the last stage.
//  - Latency: ce sampled at edge k, no stall -> done, result and tag valid in the cycle after
//    edge k+LATENCY-1. LATENCY=1 gives done in the cycle after issue.
//  - Handshake: the output is consumed on done&queued. While done&~queued, the last stage holds
//    and result/tag stay stable.
//  - Stall with bubble collapse: stage i advances if stage i+1 is empty or advancing.
//  - idle = ~valid[1] | advance[1]; idle depends on queued combinationally, never on ce (no loop).
//  - ce with idle=0 is a dispatch error; the op is ignored and pipeline state is unchanged.
//  - Same cycle done&queued and ce: the consume and the issue both happen, so full throughput
//    is 1 op/cycle.
//  - Tags are not interpreted; order of results = issue order.
// CONFIGURATION
//  FU_ALU_FLAGS_EN defined: zero_flag/ovf_flag ports exist, are computed in stage 1 and are
//    pipelined with the result. Reset value 0; they are 0 for ops other than ADD/SUB.
//  FU_ALU_FLAGS_EN undefined: the ports and flag registers are absent; all other behaviour is identical.
// STRUCTURE
//  fu_pkg: opcode localparams (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_SLL=5,
//    OP_SRL=6, OP_SRA=7, OP_SLT=8, OP_SLTU=9), OP_WIDTH, shared by dispatch decode.
//  Sub-module fu_alu_core: purely combinational op/operand -> result(+flags).
//  fu_alu_pipe: stage regs, valid/advance chain, handshake.
// TESTING
//  1 LATENCY=1: ce, SUB, d1=10, d0=3, tag=5, queued=1 -> next cycle done=1, result=7, tag=5, idle=1.
//  2 LATENCY=3, 3 back-to-back issues with queued=1 -> done for 3 consecutive cycles, tags in
//    issue order, first done 3 cycles after first issue.
//  3 LATENCY=2, queued=0 held: fill pipe -> idle=0 after 2 issues; result held stable;
//    set queued=1 for 1 cycle -> exactly one result consumed, idle=1.
//  4 SRA d1=32'h8000_0000, d0=4 -> 32'hF800_0000; SLT d1=-1, d0=1 -> 1; SLTU same -> 0.
//  5 rst asserted with 2 ops in flight -> next cycle done=0, idle=1, no stale result appears later.
//  6 FLAGS_EN: ADD 32'h7FFF_FFFF+1 -> ovf_flag=1, zero_flag=0; SUB 5-5 -> zero_flag=1.

Source files
------------

// File: rtl/fu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fu_pkg
//  Description : Shared opcode encoding for the integer functional units and
//                for the dispatch decode that feeds them.
//  Revision    : 1.0  initial release
// ============================================================================
package fu_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_SRA  = 4'd7;
    localparam logic [OP_WIDTH-1:0] OP_SLT  = 4'd8;
    localparam logic [OP_WIDTH-1:0] OP_SLTU = 4'd9;

    // Unassigned encoding. Loading it into an empty stage makes the core
    // produce result=0 and both flags=0, which is the required reset view.
    localparam logic [OP_WIDTH-1:0] OP_RESET = 4'hF;

endpackage
`default_nettype wire

// File: rtl/fu_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : fu_alu_core
//  Description : Purely combinational integer ALU: opcode + operands -> result
//                (and zero/overflow flags when FU_ALU_FLAGS_EN is defined).
//  Ports       : op      - operation select (fu_pkg encoding)
//                data_0  - subtrahend / shift amount / rhs
//                data_1  - minuend / shifted value / lhs
//                result  - operation result, 0 for undefined opcodes
//                zero_flag, ovf_flag - [FU_ALU_FLAGS_EN] ADD/SUB only
//  Config      : FU_ALU_FLAGS_EN
//  Revision    : 1.0  initial release
// ============================================================================
module fu_alu_core
    import fu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
`ifdef FU_ALU_FLAGS_EN
    output logic                  zero_flag,
    output logic                  ovf_flag,
`endif
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;

    assign w_shamt = data_0[SHW-1:0];
    assign w_sum   = data_1 + data_0;
    assign w_diff  = data_1 - data_0;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = w_sum;
            OP_SUB:  result = w_diff;
            OP_AND:  result = data_1 & data_0;
            OP_OR:   result = data_1 | data_0;
            OP_XOR:  result = data_1 ^ data_0;
            OP_SLL:  result = data_1 << w_shamt;
            OP_SRL:  result = data_1 >> w_shamt;
            OP_SRA:  result = $signed(data_1) >>> w_shamt;
            OP_SLT:  result[0] = $signed(data_1) < $signed(data_0);
            OP_SLTU: result[0] = data_1 < data_0;
            default: result = '0;
        endcase
    end

`ifdef FU_ALU_FLAGS_EN
    // Signed overflow: ADD overflows when both operands share a sign that the
    // sum does not; SUB (d1-d0) when the operand signs differ and the
    // difference's sign differs from the minuend's.
    always_comb begin
        zero_flag = 1'b0;
        ovf_flag  = 1'b0;
        if (op == OP_ADD) begin
            zero_flag = (w_sum == '0);
            ovf_flag  = (data_1[MSB] == data_0[MSB]) && (w_sum[MSB] != data_1[MSB]);
        end else if (op == OP_SUB) begin
            zero_flag = (w_diff == '0);
            ovf_flag  = (data_1[MSB] != data_0[MSB]) && (w_diff[MSB] != data_1[MSB]);
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/fu_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fu_alu_pipe
//  Description : Pipelined multi-op integer functional unit. Accepts one op
//                per cycle, keeps up to LATENCY ops in flight and presents
//                each result with its execution tag until the broadcast
//                queue accepts it. Stalls collapse bubbles.
//  Ports       : clk, rst (sync, active-high)
//                ce / idle          - issue strobe / stage 1 can accept
//                op, executionTag_in, data_0, data_1 - issued op
//                result, done, executionTag_out     - output stage
//                queued             - output consumed this cycle
//                zero_flag, ovf_flag - [FU_ALU_FLAGS_EN] pipelined flags
//  Config      : FU_ALU_FLAGS_EN adds the flag ports and flag registers.
//  Revision    : 1.0  initial release
// ============================================================================
module fu_alu_pipe
    import fu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1,
    parameter int TAG_WIDTH  = 7,
    parameter int OP_WIDTH   = fu_pkg::OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    output logic                  idle,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [TAG_WIDTH-1:0]  executionTag_in,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic [TAG_WIDTH-1:0]  executionTag_out,
`ifdef FU_ALU_FLAGS_EN
    output logic                  zero_flag,
    output logic                  ovf_flag,
`endif
    input  logic                  queued
);

    // Stage 1 (index 0) holds the raw op; the core evaluates it directly.
    logic [LATENCY-1:0]    r_valid;
    logic [OP_WIDTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;
    logic [TAG_WIDTH-1:0]  r_tag1;

    logic [DATA_WIDTH-1:0] w_res;
`ifdef FU_ALU_FLAGS_EN
    logic                  w_zf;
    logic                  w_of;
`endif

    // w_free[i]: stage i may be written at the next edge (empty or its
    // contents move on). Computed from the output stage backwards.
    logic [LATENCY-1:0]    w_free;
    logic                  w_carry;

    fu_alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .op        (r_op),
        .data_0    (r_d0),
        .data_1    (r_d1),
`ifdef FU_ALU_FLAGS_EN
        .zero_flag (w_zf),
        .ovf_flag  (w_of),
`endif
        .result    (w_res)
    );

    always_comb begin
        w_free  = '0;
        w_carry = queued;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            w_carry   = ~r_valid[i] | w_carry;
            w_free[i] = w_carry;
        end
    end

    // Depends on queued and state only, never on ce.
    assign idle = w_free[0];
    assign done = r_valid[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_op    <= OP_RESET;
            r_d0    <= '0;
            r_d1    <= '0;
            r_tag1  <= '0;
        end else begin
            for (int i = LATENCY - 1; i >= 1; i--) begin
                if (w_free[i]) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
            // ce while stage 1 is blocked is a dispatch error and is dropped.
            if (w_free[0]) begin
                r_valid[0] <= ce;
                if (ce) begin
                    r_op   <= op;
                    r_d0   <= data_0;
                    r_d1   <= data_1;
                    r_tag1 <= executionTag_in;
                end
            end
        end
    end

    if (LATENCY > 1) begin : g_pipe
        logic [DATA_WIDTH-1:0] r_res [1:LATENCY-1];
        logic [TAG_WIDTH-1:0]  r_tag [1:LATENCY-1];
`ifdef FU_ALU_FLAGS_EN
        logic                  r_zf  [1:LATENCY-1];
        logic                  r_of  [1:LATENCY-1];
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 1; i <= LATENCY - 1; i++) begin
                    r_res[i] <= '0;
                    r_tag[i] <= '0;
`ifdef FU_ALU_FLAGS_EN
                    r_zf[i]  <= 1'b0;
                    r_of[i]  <= 1'b0;
`endif
                end
            end else begin
                if (w_free[1] && r_valid[0]) begin
                    r_res[1] <= w_res;
                    r_tag[1] <= r_tag1;
`ifdef FU_ALU_FLAGS_EN
                    r_zf[1]  <= w_zf;
                    r_of[1]  <= w_of;
`endif
                end
                for (int i = 2; i <= LATENCY - 1; i++) begin
                    if (w_free[i] && r_valid[i-1]) begin
                        r_res[i] <= r_res[i-1];
                        r_tag[i] <= r_tag[i-1];
`ifdef FU_ALU_FLAGS_EN
                        r_zf[i]  <= r_zf[i-1];
                        r_of[i]  <= r_of[i-1];
`endif
                    end
                end
            end
        end

        assign result           = r_res[LATENCY-1];
        assign executionTag_out = r_tag[LATENCY-1];
`ifdef FU_ALU_FLAGS_EN
        assign zero_flag        = r_zf[LATENCY-1];
        assign ovf_flag         = r_of[LATENCY-1];
`endif
    end else begin : g_single
        // Single stage: stage 1 is the output stage; its registers hold
        // while stalled, so the combinational result stays stable.
        assign result           = w_res;
        assign executionTag_out = r_tag1;
`ifdef FU_ALU_FLAGS_EN
        assign zero_flag        = w_zf;
        assign ovf_flag         = w_of;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_fu_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_alu_pipe
//  Description : Scoreboard bench for fu_alu_pipe. Three instances with
//                LATENCY 1, 2 and 3 share the stimulus; each instance has its
//                own expected-result queue and occupancy model.
//  Config      : FU_ALU_FLAGS_EN (flag ports compared when defined)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fu_alu_pipe;
    import fu_pkg::*;

    localparam int ND = 3;
    localparam int NV = 15;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d0;
        logic [6:0]  tag;
        logic [31:0] res;
        logic        zf;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [6:0]  tag;
        logic        zf;
        logic        ovf;
        logic        lat;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        queued;
    logic [3:0]  op;
    logic [6:0]  tag_in;
    logic [31:0] d0;
    logic [31:0] d1;

    logic        idle_v [ND];
    logic        done_v [ND];
    logic [31:0] res_v  [ND];
    logic [6:0]  tag_v  [ND];
`ifdef FU_ALU_FLAGS_EN
    logic        zf_v   [ND];
    logic        of_v   [ND];
`endif

    exp_t        sbq [ND][$];
    int          cnt [ND];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        vecs [NV];
    exp_t        mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        fu_alu_pipe #(
            .DATA_WIDTH (32),
            .LATENCY    (g + 1),
            .TAG_WIDTH  (7),
            .OP_WIDTH   (4)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .ce               (ce),
            .idle             (idle_v[g]),
            .op               (op),
            .executionTag_in  (tag_in),
            .data_0           (d0),
            .data_1           (d1),
            .result           (res_v[g]),
            .done             (done_v[g]),
            .executionTag_out (tag_v[g]),
`ifdef FU_ALU_FLAGS_EN
            .zero_flag        (zf_v[g]),
            .ovf_flag         (of_v[g]),
`endif
            .queued           (queued)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: per instance, check idle against the occupancy model, compare
    // the head of the scoreboard whenever done is shown, pop on consume.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("idle_L%0d", d + 1), {63'd0, idle_v[d]},
                    {63'd0, (queued || cnt[d] < d + 1)});
                if (done_v[d]) begin
                    if (sbq[d].size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_done_L%0d: got done=1 tag=%0h expected done=0", d + 1, tag_v[d]);
                    end else begin
                        mon_e = sbq[d][0];
                        chk($sformatf("result_L%0d", d + 1), {32'd0, res_v[d]}, {32'd0, mon_e.res});
                        chk($sformatf("tag_L%0d", d + 1), {57'd0, tag_v[d]}, {57'd0, mon_e.tag});
`ifdef FU_ALU_FLAGS_EN
                        chk($sformatf("zero_flag_L%0d", d + 1), {63'd0, zf_v[d]}, {63'd0, mon_e.zf});
                        chk($sformatf("ovf_flag_L%0d", d + 1), {63'd0, of_v[d]}, {63'd0, mon_e.ovf});
`endif
                        if (queued) begin
                            if (mon_e.lat)
                                chk($sformatf("latency_L%0d", d + 1), 64'(cyc), {32'd0, mon_e.cyc});
                            void'(sbq[d].pop_front());
                        end
                    end
                end
                cnt[d] = cnt[d] + ((ce && idle_v[d]) ? 1 : 0) - ((done_v[d] && queued) ? 1 : 0);
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic issue(input vec_t v);
        exp_t e;
        #1;
        ce     = 1'b1;
        op     = v.op;
        d1     = v.d1;
        d0     = v.d0;
        tag_in = v.tag;
        for (int d = 0; d < ND; d++) begin
            if (idle_v[d]) begin
                e.res = v.res;
                e.tag = v.tag;
                e.zf  = v.zf;
                e.ovf = v.ovf;
                e.lat = queued;
                e.cyc = 32'(cyc + d + 1);
                sbq[d].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op       d1            d0            tag    res           zf    ovf
        vecs[0]  = '{OP_SUB,  32'd10,       32'd3,        7'd5,  32'd7,        1'b0, 1'b0};
        vecs[1]  = '{OP_ADD,  32'd5,        32'd7,        7'd1,  32'd12,       1'b0, 1'b0};
        vecs[2]  = '{OP_AND,  32'hF0F0_FF00, 32'h0FF0_0F0F, 7'd2, 32'h00F0_0F00, 1'b0, 1'b0};
        vecs[3]  = '{OP_OR,   32'h0000_00F0, 32'h0000_000F, 7'd3, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[4]  = '{OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 7'd4, 32'h5A5A_A5A5, 1'b0, 1'b0};
        vecs[5]  = '{OP_SLL,  32'd1,        32'h23,       7'd6,  32'd8,        1'b0, 1'b0};
        vecs[6]  = '{OP_SRL,  32'h8000_0000, 32'd4,       7'd7,  32'h0800_0000, 1'b0, 1'b0};
        vecs[7]  = '{OP_SRA,  32'h8000_0000, 32'd4,       7'd8,  32'hF800_0000, 1'b0, 1'b0};
        vecs[8]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,       7'd9,  32'd1,        1'b0, 1'b0};
        vecs[9]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,       7'd10, 32'd0,        1'b0, 1'b0};
        vecs[10] = '{OP_ADD,  32'hFFFF_FFFF, 32'd2,       7'd11, 32'd1,        1'b0, 1'b0};
        vecs[11] = '{OP_ADD,  32'h7FFF_FFFF, 32'd1,       7'd12, 32'h8000_0000, 1'b0, 1'b1};
        vecs[12] = '{OP_SUB,  32'd5,        32'd5,        7'd13, 32'd0,        1'b1, 1'b0};
        vecs[13] = '{OP_SUB,  32'h8000_0000, 32'd1,       7'd14, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[14] = '{4'hC,    32'h1234,     32'h5678,     7'd15, 32'd0,        1'b0, 1'b0};

        for (int d = 0; d < ND; d++) cnt[d] = 0;
        rst = 1'b1; ce = 1'b0; queued = 1'b0;
        op = '0; tag_in = '0; d0 = '0; d1 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset_done_L%0d", d + 1), {63'd0, done_v[d]}, 64'd0);
            chk($sformatf("reset_idle_L%0d", d + 1), {63'd0, idle_v[d]}, 64'd1);
            chk($sformatf("reset_result_L%0d", d + 1), {32'd0, res_v[d]}, 64'd0);
            chk($sformatf("reset_tag_L%0d", d + 1), {57'd0, tag_v[d]}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Single SUB with queued held high
        queued = 1'b1;
        issue(vecs[0]);
        step(5);

        // Back-to-back stream through every op, full throughput
        for (int i = 1; i < NV; i++) issue(vecs[i]);
        step(6);

        // Fill under backpressure, extra ce while full is dropped
        queued = 1'b0;
        for (int i = 11; i < 15; i++) issue(vecs[i]);
        step(3);
        queued = 1'b1;
        step(1);
        queued = 1'b0;
        step(3);
        queued = 1'b1;
        step(6);

        // Reset with ops in flight
        queued = 1'b0;
        issue(vecs[1]);
        issue(vecs[2]);
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            sbq[d].delete();
            cnt[d] = 0;
        end
        step(1);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("flush_done_L%0d", d + 1), {63'd0, done_v[d]}, 64'd0);
            chk($sformatf("flush_idle_L%0d", d + 1), {63'd0, idle_v[d]}, 64'd1);
        end
        @(posedge clk);
        #1;
        queued = 1'b1;
        step(6);

        for (int d = 0; d < ND; d++)
            chk($sformatf("drained_L%0d", d + 1), 64'(sbq[d].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
